// File: rtl/matrix_inverse_gj_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// matrix_inverse_gj_if : valid/ready matrix bundle for the Gauss-Jordan inverter
// Rev 1.0
// ----------------------------------------------------------------------------
interface matrix_inverse_gj_if #(
   parameter int N = 4,
   parameter int W = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [N*N*W-1:0] a_in;
   logic             out_valid;
   logic             out_ready;
   logic [N*N*W-1:0] b_out;
   logic             singular;
   logic             busy;

   modport master (
      output in_valid, a_in, out_ready,
      input  in_ready, out_valid, b_out, singular, busy
   );

   modport slave (
      input  in_valid, a_in, out_ready,
      output in_ready, out_valid, b_out, singular, busy
   );
endinterface

`default_nettype wire

// File: rtl/matrix_inverse_gj.sv
`default_nettype none
// ----------------------------------------------------------------------------
// matrix_inverse_gj : N x N signed fixed-point inverse, Gauss-Jordan with partial pivoting
// Rev 1.0
// ----------------------------------------------------------------------------
module matrix_inverse_gj #(
   parameter int N    = 4,
   parameter int W    = 32,
   parameter int FRAC = 12
) (
   input  logic               clk,
   input  logic               rst,
   matrix_inverse_gj_if.slave bus
);

   localparam int c_RW   = $clog2(N);
   localparam int c_CW   = $clog2(2 * N);
   localparam int c_QW   = W + FRAC;
   localparam int c_CNTW = $clog2(c_QW + 1);

   localparam logic [c_RW-1:0]   c_LAST_ROW  = c_RW'(N - 1);
   localparam logic [c_CW-1:0]   c_LAST_COL  = c_CW'(2 * N - 1);
   localparam logic [c_RW:0]     c_NROWS     = (c_RW + 1)'(N);
   localparam logic [c_CNTW-1:0] c_LAST_ITER = c_CNTW'(c_QW - 1);

   localparam logic signed [W-1:0] c_ONE  = W'(1 << FRAC);
   localparam logic signed [W-1:0] c_WMAX = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0] c_WMIN = {1'b1, {(W-1){1'b0}}};
   localparam logic signed [2*W:0] c_SMAX = {{(W+2){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [2*W:0] c_SMIN = {{(W+2){1'b1}}, {(W-1){1'b0}}};
   localparam logic [c_QW-1:0]     c_DIVIDEND = {{(c_QW-1){1'b0}}, 1'b1} << (2 * FRAC);
   localparam logic [c_QW-1:0]     c_QPOS = {{(FRAC+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic [c_QW-1:0]     c_QNEG = {{FRAC{1'b0}}, 1'b1, {(W-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SEARCH = 3'd1,
      S_SWAP   = 3'd2,
      S_RECIP  = 3'd3,
      S_NORM   = 3'd4,
      S_ELIM   = 3'd5,
      S_OUTPUT = 3'd6
   } state_t;

   state_t              state_q;
   logic signed [W-1:0] m_q [N][2*N];
   logic [c_RW-1:0]     k_q, r_q, piv_q, i_q;
   logic [c_CW-1:0]     j_q;
   logic [W-1:0]        max_q;
   logic signed [W-1:0] f_q, recip_q;
   logic [W-1:0]        rem_q, div_q;
   logic [c_QW-1:0]     quo_q;
   logic [c_CNTW-1:0]   cnt_q;
   logic                neg_q, rsetup_q;
   logic                in_ready_q, out_valid_q, singular_q, busy_q;
   logic [N*N*W-1:0]    b_out_q;

   function automatic logic [W-1:0] f_abs(input logic signed [W-1:0] x);
      return x[W-1] ? ((~x) + W'(1)) : x;
   endfunction

   function automatic logic signed [W-1:0] f_sat(input logic signed [2*W:0] x);
      if (x > c_SMAX)      return c_WMAX;
      else if (x < c_SMIN) return c_WMIN;
      else                 return x[W-1:0];
   endfunction

   // Pivot search: running maximum of |M[r][k]|, strict compare keeps the lowest row on ties
   logic [W-1:0]    w_abs, w_max;
   logic            w_better;
   logic [c_RW-1:0] w_piv;

   assign w_abs    = f_abs(m_q[r_q][k_q]);
   assign w_better = (r_q == k_q) || (w_abs > max_q);
   assign w_max    = w_better ? w_abs : max_q;
   assign w_piv    = w_better ? r_q : piv_q;

   // One shared multiplier: NORM scales row k by recip, ELIM scales row k by f
   logic signed [W-1:0]   w_mk, w_mi, w_mul_a, w_mul_b;
   logic signed [2*W-1:0] w_prod, w_shift;
   logic signed [2*W:0]   w_diff;
   logic signed [W-1:0]   w_norm, w_elim;

   assign w_mk    = m_q[k_q][j_q];
   assign w_mi    = m_q[i_q][j_q];
   assign w_mul_a = (state_q == S_NORM) ? w_mk : f_q;
   assign w_mul_b = (state_q == S_NORM) ? recip_q : w_mk;
   assign w_prod  = w_mul_a * w_mul_b;
   assign w_shift = w_prod >>> FRAC;
   assign w_norm  = f_sat($signed({w_shift[2*W-1], w_shift}));
   assign w_diff  = $signed({{(W+1){w_mi[W-1]}}, w_mi}) - $signed({w_shift[2*W-1], w_shift});
   assign w_elim  = f_sat(w_diff);

   // Restoring divider step; quotient bits shift in behind the dividend
   logic [W-1:0]        w_rem_sh, w_rem_nx;
   logic                w_ge;
   logic [c_QW-1:0]     w_quo_nx;
   logic signed [W-1:0] w_recip;

   assign w_rem_sh = {rem_q[W-2:0], quo_q[c_QW-1]};
   assign w_ge     = (w_rem_sh >= div_q);
   assign w_rem_nx = w_ge ? (w_rem_sh - div_q) : w_rem_sh;
   assign w_quo_nx = {quo_q[c_QW-2:0], w_ge};

   always_comb begin
      w_recip = '0;
      if (!neg_q) begin
         w_recip = (w_quo_nx > c_QPOS) ? c_WMAX : w_quo_nx[W-1:0];
      end else begin
         w_recip = (w_quo_nx > c_QNEG) ? c_WMIN : ((~w_quo_nx[W-1:0]) + W'(1));
      end
   end

   // Row walk for elimination skips the pivot row k
   logic [c_RW:0]   w_ni1, w_ni;
   logic            w_rows_done;
   logic [c_RW-1:0] w_first;

   assign w_ni1       = {1'b0, i_q} + (c_RW + 1)'(1);
   assign w_ni        = (w_ni1 == {1'b0, k_q}) ? (w_ni1 + (c_RW + 1)'(1)) : w_ni1;
   assign w_rows_done = (w_ni >= c_NROWS);
   assign w_first     = (k_q == '0) ? c_RW'(1) : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         k_q         <= '0;
         r_q         <= '0;
         piv_q       <= '0;
         i_q         <= '0;
         j_q         <= '0;
         max_q       <= '0;
         f_q         <= '0;
         recip_q     <= '0;
         rem_q       <= '0;
         div_q       <= '0;
         quo_q       <= '0;
         cnt_q       <= '0;
         neg_q       <= 1'b0;
         rsetup_q    <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         singular_q  <= 1'b0;
         busy_q      <= 1'b0;
         b_out_q     <= '0;
         for (int r = 0; r < N; r++) begin
            for (int c = 0; c < 2 * N; c++) begin
               m_q[r][c] <= '0;
            end
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.in_valid && in_ready_q) begin
                  for (int r = 0; r < N; r++) begin
                     for (int c = 0; c < N; c++) begin
                        m_q[r][c]     <= bus.a_in[(r*N+c)*W +: W];
                        m_q[r][N + c] <= (r == c) ? c_ONE : '0;
                     end
                  end
                  k_q        <= '0;
                  r_q        <= '0;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  singular_q <= 1'b0;
                  state_q    <= S_SEARCH;
               end
            end
            S_SEARCH: begin
               max_q <= w_max;
               piv_q <= w_piv;
               if (r_q == c_LAST_ROW) begin
                  if (w_max == '0) begin
                     singular_q <= 1'b1;
                     state_q    <= S_OUTPUT;
                  end else begin
                     state_q <= S_SWAP;
                  end
               end else begin
                  r_q <= r_q + c_RW'(1);
               end
            end
            S_SWAP: begin
               if (piv_q != k_q) begin
                  for (int c = 0; c < 2 * N; c++) begin
                     m_q[k_q][c]   <= m_q[piv_q][c];
                     m_q[piv_q][c] <= m_q[k_q][c];
                  end
               end
               rsetup_q <= 1'b1;
               state_q  <= S_RECIP;
            end
            S_RECIP: begin
               if (rsetup_q) begin
                  rsetup_q <= 1'b0;
                  div_q    <= f_abs(m_q[k_q][k_q]);
                  neg_q    <= m_q[k_q][k_q][W-1];
                  rem_q    <= '0;
                  quo_q    <= c_DIVIDEND;
                  cnt_q    <= '0;
               end else begin
                  rem_q <= w_rem_nx;
                  quo_q <= w_quo_nx;
                  cnt_q <= cnt_q + c_CNTW'(1);
                  if (cnt_q == c_LAST_ITER) begin
                     recip_q <= w_recip;
                     j_q     <= '0;
                     state_q <= S_NORM;
                  end
               end
            end
            S_NORM: begin
               m_q[k_q][j_q] <= w_norm;
               if (j_q == c_LAST_COL) begin
                  j_q     <= '0;
                  i_q     <= w_first;
                  f_q     <= m_q[w_first][k_q];
                  state_q <= S_ELIM;
               end else begin
                  j_q <= j_q + c_CW'(1);
               end
            end
            S_ELIM: begin
               m_q[i_q][j_q] <= w_elim;
               if (j_q == c_LAST_COL) begin
                  j_q <= '0;
                  if (!w_rows_done) begin
                     i_q <= w_ni[c_RW-1:0];
                     f_q <= m_q[w_ni[c_RW-1:0]][k_q];
                  end else if (k_q == c_LAST_ROW) begin
                     state_q <= S_OUTPUT;
                  end else begin
                     k_q     <= k_q + c_RW'(1);
                     r_q     <= k_q + c_RW'(1);
                     state_q <= S_SEARCH;
                  end
               end else begin
                  j_q <= j_q + c_CW'(1);
               end
            end
            S_OUTPUT: begin
               // First cycle captures the result so the final ELIM write is included
               if (!out_valid_q) begin
                  for (int r = 0; r < N; r++) begin
                     for (int c = 0; c < N; c++) begin
                        b_out_q[(r*N+c)*W +: W] <= singular_q ? '0 : m_q[r][N + c];
                     end
                  end
                  out_valid_q <= 1'b1;
               end else if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.b_out     = b_out_q;
   assign bus.singular  = singular_q;
   assign bus.busy      = busy_q;

endmodule

`default_nettype wire
